// File: rtl/buraq_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: group code, func3
// encodings and the control FSM state type.
package buraq_pkg;

    localparam logic [2:0] M_GRP     = 3'b011;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_divider.sv
// Iterative radix-2 restoring divider on unsigned 32-bit magnitudes.
// Takes 32 cycles after start_i; done_o pulses the cycle after the last step.
module muldiv_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        act_q, act_d, done_q, done_d;
    logic [32:0] shifted, diff;

    always_comb begin
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        done_d  = 1'b0;
        // quo_q doubles as the dividend shift register: its MSB feeds the
        // partial remainder while quotient bits enter at the LSB.
        shifted = {rem_q, quo_q[31]};
        diff    = shifted - {1'b0, dvs_q};
        if (start_i) begin
            quo_d = dividend_i;
            rem_d = '0;
            dvs_d = divisor_i;
            cnt_d = '0;
            act_d = 1'b1;
        end else if (act_q) begin
            if (diff[32]) begin
                rem_d = shifted[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end else begin
                rem_d = diff[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                act_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            act_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            done_q <= done_d;
        end
    end

    assign done_o      = done_q;
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: single-cycle 33x33 multiply, iterative divide
// with sign fixup, result held until overwritten by the next operation.
module muldiv_unit
    import buraq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  alu_control_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    state_e      state_q, state_d;
    logic [31:0] a_q, b_q, result_q, result_d;
    logic [2:0]  f3_q;
    logic        accept, req_signed;
    logic [31:0] dvd_mag, dvs_mag;
    logic        div_done;
    logic [31:0] div_quo, div_rem;

    assign busy_o = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign done_o = (state_q == ST_DONE);
    assign accept = start_i && !busy_o && (alu_control_i[5:3] == M_GRP);

    // Divider is fed magnitudes straight from the ports at acceptance so its
    // 32 iterations begin on the very next edge.
    assign req_signed = ~alu_control_i[0];
    assign dvd_mag = (req_signed && operand_a_i[31]) ? -operand_a_i : operand_a_i;
    assign dvs_mag = (req_signed && operand_b_i[31]) ? -operand_b_i : operand_b_i;

    muldiv_divider u_div (
        .clk         (clk),
        .rst         (rst),
        .start_i     (accept && alu_control_i[2]),
        .dividend_i  (dvd_mag),
        .divisor_i   (dvs_mag),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    logic signed [32:0] ma, mb;
    logic signed [63:0] prod;
    logic [31:0]        mul_res;

    always_comb begin
        ma      = {(f3_q == F3_MULH || f3_q == F3_MULHSU) && a_q[31], a_q};
        mb      = {(f3_q == F3_MULH) && b_q[31], b_q};
        prod    = 64'(ma) * 64'(mb);
        mul_res = (f3_q == F3_MUL) ? prod[31:0] : prod[63:32];
    end

    logic        div_signed;
    logic [31:0] div_res;

    always_comb begin
        div_signed = ~f3_q[0];
        if (b_q == 32'd0)
            div_res = f3_q[1] ? a_q : 32'hFFFF_FFFF;
        else if (f3_q[1])
            div_res = (div_signed && a_q[31]) ? -div_rem : div_rem;
        else
            div_res = (div_signed && (a_q[31] ^ b_q[31])) ? -div_quo : div_quo;
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept)
                    state_d = alu_control_i[2] ? ST_DIV : ST_MUL;
                else
                    state_d = ST_IDLE;
            end
            ST_MUL: begin
                state_d  = ST_DONE;
                result_d = mul_res;
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d  = ST_DONE;
                    result_d = div_res;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            f3_q     <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            if (accept) begin
                a_q  <= operand_a_i;
                b_q  <= operand_b_i;
                f3_q <= alu_control_i[2:0];
            end
        end
    end

    assign result_o = result_q;

endmodule
